// File: rtl/i2s_master_tx.sv
// I2S bus master transmitter: generates bclk (64 x lrclk) and lrclk, and serialises a stereo pair per frame.
// Optional macro LEFT_JUSTIFIED_EN selects left-justified framing instead of standard I2S (one-bit delay).
module i2s_master_tx #(
   parameter int unsigned BITSIZE = 24,
   parameter int unsigned CLKDIV  = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic [BITSIZE-1:0] left_in,
   input  logic [BITSIZE-1:0] right_in,
   output logic               sample_req,
   output logic               bclk,
   output logic               lrclk,
   output logic               sdata
);

   localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int unsigned IW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
`ifdef LEFT_JUSTIFIED_EN
   localparam int unsigned MAX_BITS = 32;
`else
   localparam int unsigned MAX_BITS = 31;
`endif

   if (BITSIZE < 1 || BITSIZE > MAX_BITS) begin : g_bad_bitsize
      $error("i2s_master_tx: BITSIZE out of range");
   end
   if (CLKDIV < 1) begin : g_bad_clkdiv
      $error("i2s_master_tx: CLKDIV must be >= 1");
   end

   logic [DW-1:0]      div_cnt;
   logic [5:0]         bit_cnt;
   logic [BITSIZE-1:0] hold_l;
   logic [BITSIZE-1:0] hold_r;

   logic               div_tc_c;
   logic               fall_c;
   logic               frame_start_c;
   logic [5:0]         bit_cnt_nxt_c;
   logic [BITSIZE-1:0] hold_l_nxt_c;
   logic [BITSIZE-1:0] hold_r_nxt_c;
   logic [BITSIZE-1:0] word_c;
   logic [4:0]         pos_c;
   logic [IW-1:0]      idx_c;
   logic               sdata_nxt_c;

   // Next-bit selection: sdata is computed from the post-fall slot position and holds
   always_comb begin
      div_tc_c      = (div_cnt == DW'(CLKDIV - 1));
      fall_c        = div_tc_c & bclk;
      frame_start_c = fall_c & (bit_cnt == 6'd63);
      bit_cnt_nxt_c = bit_cnt + 6'd1;
      hold_l_nxt_c  = hold_l;
      hold_r_nxt_c  = hold_r;
      idx_c         = '0;
      sdata_nxt_c   = 1'b0;
      if (frame_start_c) begin
         hold_l_nxt_c = enable ? left_in  : '0;
         hold_r_nxt_c = enable ? right_in : '0;
      end
      pos_c  = bit_cnt_nxt_c[4:0];
      word_c = bit_cnt_nxt_c[5] ? hold_r_nxt_c : hold_l_nxt_c;
`ifdef LEFT_JUSTIFIED_EN
      if (32'(pos_c) < BITSIZE) begin
         idx_c       = IW'(BITSIZE - 32'd1 - 32'(pos_c));
         sdata_nxt_c = word_c[idx_c];
      end
`else
      if (pos_c != 5'd0 && 32'(pos_c) <= BITSIZE) begin
         idx_c       = IW'(BITSIZE - 32'(pos_c));
         sdata_nxt_c = word_c[idx_c];
      end
`endif
   end

   // Clock divider, bit counter and serial output; state moves only on bclk fall events
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt    <= '0;
         bclk       <= 1'b0;
         bit_cnt    <= 6'd63;
         lrclk      <= 1'b1;
         sdata      <= 1'b0;
         sample_req <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
      end else begin
         sample_req <= frame_start_c;
         if (div_tc_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
         if (fall_c) begin
            bit_cnt <= bit_cnt_nxt_c;
            lrclk   <= bit_cnt_nxt_c[5];
            hold_l  <= hold_l_nxt_c;
            hold_r  <= hold_r_nxt_c;
            sdata   <= sdata_nxt_c;
         end
      end
   end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: per-cycle check against a time-indexed frame model plus literal slot checks.
// Honours LEFT_JUSTIFIED_EN the same way as the design.
module tb_i2s_master_tx;

   localparam int BS    = 24;
   localparam int CD    = 2;
   localparam int FRAME = 128 * CD;

   logic          clk      = 1'b0;
   logic          resetn   = 1'b0;
   logic          enable   = 1'b1;
   logic [BS-1:0] left_in  = '0;
   logic [BS-1:0] right_in = '0;
   logic          sample_req;
   logic          bclk;
   logic          lrclk;
   logic          sdata;

   int checks   = 0;
   int failures = 0;

   i2s_master_tx #(.BITSIZE(BS), .CLKDIV(CD)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .left_in    (left_in),
      .right_in   (right_in),
      .sample_req (sample_req),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdata      (sdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Slot word as seen on the wire, first transmitted bit in bit 31
   function automatic logic [31:0] exp_slot(input logic [BS-1:0] v);
`ifdef LEFT_JUSTIFIED_EN
      return 32'(v) << (32 - BS);
`else
      return 32'(v) << (31 - BS);
`endif
   endfunction

   function automatic logic model_bit(input logic [31:0] w, input int p);
      logic [31:0] t;
`ifdef LEFT_JUSTIFIED_EN
      if (p < BS) begin
         t = w >> (BS - 1 - p);
         return t[0];
      end
`else
      if (p >= 1 && p <= BS) begin
         t = w >> (BS - p);
         return t[0];
      end
`endif
      return 1'b0;
   endfunction

   // Model state: n = clk edges since reset release
   int          n = 0;
   int          k, bc, lr, p;
   logic [31:0] ml = '0, mr = '0;
   logic        e_bclk, e_req, e_sdata, prev_b = 1'b0;
   logic [31:0] cap = '0, cap_l = '0, cap_r = '0;
   int          frames_done = 0;
   int          req_count   = 0;

   always begin
      @(posedge clk);
      if (!resetn) begin
         n = 0; ml = '0; mr = '0; cap = '0; prev_b = 1'b0;
      end else begin
         n++;
         if (n % (2*CD) == 0 && ((n / (2*CD)) - 1) % 64 == 0) begin
            ml = enable ? 32'(left_in)  : 32'd0;
            mr = enable ? 32'(right_in) : 32'd0;
         end
      end
      #1;
      k       = n / (2*CD);
      bc      = (k == 0) ? 63 : (k - 1) % 64;
      lr      = bc / 32;
      p       = bc % 32;
      e_bclk  = ((n / CD) % 2) == 1;
      e_req   = (n > 0) && (n % (2*CD) == 0) && ((k - 1) % 64 == 0);
      e_sdata = model_bit((lr == 1) ? mr : ml, p);
      chk1("bclk",       bclk,       e_bclk);
      chk1("lrclk",      lrclk,      lr == 1);
      chk1("sample_req", sample_req, e_req);
      chk1("sdata",      sdata,      e_sdata);
      if (sample_req === 1'b1) req_count++;
      if (k >= 1 && e_bclk && !prev_b) begin
         cap = {cap[30:0], sdata};
         if (p == 31) begin
            if (lr == 0) cap_l = cap;
            else begin
               cap_r = cap;
               frames_done++;
            end
         end
      end
      prev_b = e_bclk;
   end

   task automatic wait_frame();
      int start;
      int t;
      start = frames_done;
      t = 0;
      while (frames_done == start && t < 2*FRAME) begin
         @(negedge clk);
         t++;
      end
      chk1("frame_timeout", frames_done != start, 1'b1);
   endtask

   initial begin
      int t;
      int r0;
      logic [BS-1:0] r1, r2;

      left_in  = 24'hA5A5A5;
      right_in = 24'h5A5A5A;
      repeat (3) @(negedge clk);
      chk1("rst_bclk",  bclk,       1'b0);
      chk1("rst_lrclk", lrclk,      1'b1);
      chk1("rst_sdata", sdata,      1'b0);
      chk1("rst_req",   sample_req, 1'b0);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk1("req_early", sample_req, 1'b0);
      @(posedge clk);
      #1;
      chk1("first_req",   sample_req, 1'b1);
      chk1("first_lrclk", lrclk,      1'b0);

      wait_frame();
`ifdef LEFT_JUSTIFIED_EN
      chk("slot_l_a5", cap_l, 32'hA5A5A500);
      chk("slot_r_5a", cap_r, 32'h5A5A5A00);
`else
      chk("slot_l_a5", cap_l, 32'h52D2D280);
      chk("slot_r_5a", cap_r, 32'h2D2D2D00);
`endif

      left_in  = 24'hC00001;
      right_in = 24'h800000;
      r0 = req_count;
      wait_frame();
      chk("req_per_frame", 32'(req_count - r0), 32'd1);
`ifdef LEFT_JUSTIFIED_EN
      chk("slot_l_c00001", cap_l, 32'hC0000100);
      chk("slot_r_negfs",  cap_r, 32'h80000000);
`else
      chk("slot_l_c00001", cap_l, 32'h60000080);
      chk("slot_r_negfs",  cap_r, 32'h40000000);
`endif

      repeat (40) @(negedge clk);
      left_in = 24'h123456;
      wait_frame();
      chk("no_tearing", cap_l, exp_slot(24'hC00001));
      wait_frame();
`ifdef LEFT_JUSTIFIED_EN
      chk("slot_l_new", cap_l, 32'h12345600);
`else
      chk("slot_l_new", cap_l, 32'h091A2B00);
`endif

      repeat (100) @(negedge clk);
      enable = 1'b0;
      wait_frame();
      chk("mute_intact", cap_l, exp_slot(24'h123456));
      wait_frame();
      chk("mute_l", cap_l, 32'd0);
      chk("mute_r", cap_r, 32'd0);
      enable   = 1'b1;
      right_in = 24'h7FFFFF;

      t = 0;
      while (lrclk !== 1'b0 && t < 2*FRAME) begin @(negedge clk); t++; end
      while (lrclk !== 1'b1 && t < 2*FRAME) begin @(negedge clk); t++; end
      chk1("find_right_slot", t < 2*FRAME, 1'b1);
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk1("async_bclk",  bclk,       1'b0);
      chk1("async_lrclk", lrclk,      1'b1);
      chk1("async_sdata", sdata,      1'b0);
      chk1("async_req",   sample_req, 1'b0);
      repeat (2) @(negedge clk);
      r1 = BS'($urandom);
      r2 = BS'($urandom);
      left_in  = r1;
      right_in = r2;
      resetn   = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk1("rerelease_req", sample_req, 1'b1);
      wait_frame();
      chk("rerelease_l", cap_l, exp_slot(r1));
      chk("rerelease_r", cap_r, exp_slot(r2));

      // Random inputs and enable at arbitrary times; the per-cycle model checks every bit
      for (int i = 0; i < 6*FRAME; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0) begin
            left_in  = BS'($urandom);
            right_in = BS'($urandom);
            enable   = ($urandom_range(0, 4) != 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
